// File: rtl/lsu_pkg.sv
// Shared types and constants for the second-generation load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Access size encodings, log2 of the byte count.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Field positions inside read_t.
  localparam int RT_SIZE_LSB = 0;
  localparam int RT_SIZE_MSB = 1;
  localparam int RT_ZEXT     = 2;

  // True for the two error responses (bit[1] set).
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

  // True when the low address bits are not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic [2:0] mask;
    mask = 3'((4'd1 << size) - 4'd1);
    return |(addr_lo & mask);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: store shift/strobe generation and load shift/extend.
// Purely combinational; also intended for the DCache refill path.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]  i_offset,
  input  logic [1:0]        i_size,
  input  logic              i_zext,
  input  logic [DATA_W-1:0] i_st_data,
  output logic [DATA_W-1:0] o_st_data,
  output logic [STRB_W-1:0] o_st_strb,
  input  logic [DATA_W-1:0] i_ld_raw,
  output logic [DATA_W-1:0] o_ld_data
);

  logic [OFF_W+2:0]  w_shamt;
  logic [STRB_W-1:0] w_mask;
  logic [DATA_W-1:0] w_ld_shift;
  logic [DATA_W-1:0] w_word_ext;

  assign w_shamt    = {i_offset, 3'b000};
  assign o_st_data  = i_st_data << w_shamt;
  // Lanes shifted past the top of the bus word simply fall off.
  assign o_st_strb  = w_mask << i_offset;
  assign w_ld_shift = i_ld_raw >> w_shamt;

  // Unshifted strobe mask for the access size.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_mask = '1;
    case (i_size)
      SZ_B:    w_mask = STRB_W'(4'b0001);
      SZ_H:    w_mask = STRB_W'(4'b0011);
      SZ_W:    w_mask = STRB_W'(4'b1111);
      default: w_mask = '1;
    endcase
  end

  // Word extension only exists when the bus is wider than a word.
  if (DATA_W > 32) begin : g_word_ext
    assign w_word_ext = {{(DATA_W-32){~i_zext & w_ld_shift[31]}}, w_ld_shift[31:0]};
  end else begin : g_word_full
    assign w_word_ext = w_ld_shift;
  end

  // Truncate the shifted load data to the access size and extend it.
  always_comb begin
    o_ld_data = w_ld_shift;
    case (i_size)
      SZ_B:    o_ld_data = {{(DATA_W-8){~i_zext & w_ld_shift[7]}}, w_ld_shift[7:0]};
      SZ_H:    o_ld_data = {{(DATA_W-16){~i_zext & w_ld_shift[15]}}, w_ld_shift[15:0]};
      SZ_W:    o_ld_data = w_word_ext;
      default: o_ld_data = w_ld_shift;
    endcase
  end

endmodule

// File: rtl/lsu_axi_gen2.sv
// Second-generation LSU: one EXU request -> one single-beat AXI4 read or write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned loads/stores fault without bus traffic.
module lsu_axi_gen2
  import lsu_pkg::*;
#(
  parameter  int          DATA_W = 32,
  parameter  int          ADDR_W = 32,
  parameter  int unsigned AXI_ID = 0,
  localparam int          STRB_W = DATA_W / 8,
  localparam int          OFF_W  = $clog2(STRB_W)
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  // EXU request
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_ren,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [2:0]        i_read_t,
  // EXU result
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_fault,
  // AXI AR
  output logic              o_arvalid,
  input  logic              i_arready,
  output logic [ADDR_W-1:0] o_araddr,
  output logic [3:0]        o_arid,
  output logic [7:0]        o_arlen,
  output logic [2:0]        o_arsize,
  output logic [1:0]        o_arburst,
  // AXI R
  input  logic              i_rvalid,
  output logic              o_rready,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  // AXI AW
  output logic              o_awvalid,
  input  logic              i_awready,
  output logic [ADDR_W-1:0] o_awaddr,
  output logic [3:0]        o_awid,
  output logic [7:0]        o_awlen,
  output logic [2:0]        o_awsize,
  output logic [1:0]        o_awburst,
  // AXI W
  output logic              o_wvalid,
  input  logic              i_wready,
  output logic [DATA_W-1:0] o_wdata,
  output logic [STRB_W-1:0] o_wstrb,
  output logic              o_wlast,
  // AXI B
  input  logic              i_bvalid,
  output logic              o_bready,
  input  logic [1:0]        i_bresp
);

  state_e            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata_raw;
  logic [1:0]        r_size;
  logic              r_zext, r_is_load, r_fault, r_aw_done, r_w_done;
  logic              w_trap, w_illegal, w_aw_fin, w_w_fin;
  logic [DATA_W-1:0] w_ld_data;

  // Dword accesses cannot be expressed on a 32-bit bus.
  assign w_illegal = (DATA_W == 32) && (i_read_t[RT_SIZE_MSB:RT_SIZE_LSB] == SZ_D)
                     && (i_ren || i_wen);
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = w_illegal || ((i_ren || i_wen) &&
                  is_misaligned(i_addr[2:0], i_read_t[RT_SIZE_MSB:RT_SIZE_LSB]));
`else
  assign w_trap = w_illegal;
`endif

  assign w_aw_fin = r_aw_done || (o_awvalid && i_awready);
  assign w_w_fin  = r_w_done  || (o_wvalid  && i_wready);

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_valid) begin
                 if (w_trap)     w_next = ST_DONE;
                 else if (i_wen) w_next = ST_AW_W;
                 else if (i_ren) w_next = ST_AR;
                 else            w_next = ST_DONE;
               end
      ST_AR:   if (i_arready)           w_next = ST_R;
      ST_R:    if (i_rvalid)            w_next = ST_DONE;
      ST_AW_W: if (w_aw_fin && w_w_fin) w_next = ST_B;
      ST_B:    if (i_bvalid)            w_next = ST_DONE;
      ST_DONE: if (i_ready)             w_next = ST_IDLE;
      default:                          w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state and the per-channel done flags.
  always_comb begin
    o_ready   = (r_state == ST_IDLE);
    o_arvalid = (r_state == ST_AR);
    o_rready  = (r_state == ST_R);
    o_awvalid = (r_state == ST_AW_W) && !r_aw_done;
    o_wvalid  = (r_state == ST_AW_W) && !r_w_done;
    o_bready  = (r_state == ST_B);
    o_valid   = (r_state == ST_DONE);
  end

  // Request latch, channel completion flags and response capture.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata_raw <= '0;
      r_size      <= SZ_B;
      r_zext      <= 1'b0;
      r_is_load   <= 1'b0;
      r_fault     <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_valid) begin
          r_addr      <= i_addr;
          r_wdata     <= i_wdata;
          r_rdata_raw <= '0;
          r_size      <= i_read_t[RT_SIZE_MSB:RT_SIZE_LSB];
          r_zext      <= i_read_t[RT_ZEXT];
          r_is_load   <= i_ren && !i_wen && !w_trap;
          r_fault     <= w_trap;
          r_aw_done   <= 1'b0;
          r_w_done    <= 1'b0;
        end
        ST_R: if (i_rvalid) begin
          r_rdata_raw <= i_rdata;
          r_fault     <= resp_is_err(i_rresp);
        end
        ST_AW_W: begin
          if (o_awvalid && i_awready) r_aw_done <= 1'b1;
          if (o_wvalid && i_wready)   r_w_done  <= 1'b1;
        end
        ST_B: if (i_bvalid) r_fault <= resp_is_err(i_bresp);
        default: ;
      endcase
    end
  end

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_offset  (r_addr[OFF_W-1:0]),
    .i_size    (r_size),
    .i_zext    (r_zext),
    .i_st_data (r_wdata),
    .o_st_data (o_wdata),
    .o_st_strb (o_wstrb),
    .i_ld_raw  (r_rdata_raw),
    .o_ld_data (w_ld_data)
  );

  assign o_rdata   = (r_is_load && !r_fault) ? w_ld_data : '0;
  assign o_fault   = r_fault;
  assign o_araddr  = r_addr;
  assign o_awaddr  = r_addr;
  assign o_arid    = 4'(AXI_ID);
  assign o_awid    = 4'(AXI_ID);
  assign o_arlen   = 8'd0;
  assign o_awlen   = 8'd0;
  assign o_arsize  = {1'b0, r_size};
  assign o_awsize  = {1'b0, r_size};
  assign o_arburst = BURST_INCR;
  assign o_awburst = BURST_INCR;
  assign o_wlast   = 1'b1;

endmodule

// File: tb/tb_lsu_axi_gen2.sv
// Directed self-checking bench for lsu_axi_gen2 (DATA_W=32).
module tb_lsu_axi_gen2;
  import lsu_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready, i_ren, i_wen, o_valid, i_ready, o_fault;
  logic [31:0] i_addr, i_wdata, o_rdata;
  logic [2:0]  i_read_t;
  logic        o_arvalid, i_arready, o_rready, i_rvalid;
  logic [31:0] o_araddr, i_rdata;
  logic [3:0]  o_arid, o_awid;
  logic [7:0]  o_arlen, o_awlen;
  logic [2:0]  o_arsize, o_awsize;
  logic [1:0]  o_arburst, o_awburst, i_rresp, i_bresp;
  logic        o_awvalid, i_awready, o_wvalid, i_wready, o_wlast, i_bvalid, o_bready;
  logic [31:0] o_awaddr, o_wdata;
  logic [3:0]  o_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_axi_gen2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AXI_ID(0)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready), .i_ren(i_ren), .i_wen(i_wen),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_read_t(i_read_t),
    .o_valid(o_valid), .i_ready(i_ready), .o_rdata(o_rdata), .o_fault(o_fault),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr), .o_arid(o_arid),
    .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr), .o_awid(o_awid),
    .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .o_wlast(o_wlast),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request at a negedge, let it be accepted, return at cycle 1.
  task automatic issue(input string tag, input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] rt);
    check({tag, "_ready_idle"}, 64'(o_ready), 64'd1);
    i_valid = 1'b1; i_ren = ren; i_wen = wen; i_addr = addr; i_wdata = wdata; i_read_t = rt;
    step();
    i_valid = 1'b0; i_ren = 1'b0; i_wen = 1'b0; i_wdata = 32'h0; i_read_t = 3'd0;
  endtask

  // Retire the result from DONE and confirm the LSU is idle again.
  task automatic retire(input string tag);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check({tag, "_valid_after"}, 64'(o_valid), 64'd0);
    check({tag, "_ready_after"}, 64'(o_ready), 64'd1);
  endtask

  // Load through a zero-wait slave, optionally stalling the result for hold cycles.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] rt,
                          input logic [31:0] rdata, input logic [1:0] rresp,
                          input logic [31:0] exp_data, input logic exp_fault,
                          input logic [2:0] exp_size, input int hold);
    issue(tag, 1'b1, 1'b0, addr, 32'h0, rt);
    check({tag, "_arvalid"}, 64'(o_arvalid), 64'd1);
    check({tag, "_araddr"}, 64'(o_araddr), 64'(addr));
    check({tag, "_arsize"}, 64'(o_arsize), 64'(exp_size));
    check({tag, "_arlen"}, 64'(o_arlen), 64'd0);
    check({tag, "_arburst"}, 64'(o_arburst), 64'(BURST_INCR));
    check({tag, "_ready_busy"}, 64'(o_ready), 64'd0);
    i_arready = 1'b1;
    step();
    i_arready = 1'b0;
    check({tag, "_arvalid_drop"}, 64'(o_arvalid), 64'd0);
    check({tag, "_rready"}, 64'(o_rready), 64'd1);
    check({tag, "_valid_c2"}, 64'(o_valid), 64'd0);
    i_rvalid = 1'b1; i_rdata = rdata; i_rresp = rresp;
    step();
    i_rvalid = 1'b0; i_rdata = 32'h0BAD_F00D; i_rresp = RESP_OKAY;
    check({tag, "_valid_c3"}, 64'(o_valid), 64'd1);
    check({tag, "_rdata"}, 64'(o_rdata), 64'(exp_data));
    check({tag, "_fault"}, 64'(o_fault), 64'(exp_fault));
    check({tag, "_rready_drop"}, 64'(o_rready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_valid"}, 64'(o_valid), 64'd1);
      check({tag, "_hold_rdata"}, 64'(o_rdata), 64'(exp_data));
      check({tag, "_hold_fault"}, 64'(o_fault), 64'(exp_fault));
      check({tag, "_hold_ready"}, 64'(o_ready), 64'd0);
    end
    retire(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    i_valid = 0; i_ren = 0; i_wen = 0; i_addr = 0; i_wdata = 0; i_read_t = 0; i_ready = 0;
    i_arready = 0; i_rvalid = 0; i_rdata = 0; i_rresp = RESP_OKAY;
    i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = RESP_OKAY;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_fault", 64'(o_fault), 64'd0);
    check("rst_rdata", 64'(o_rdata), 64'd0);
    check("rst_axi_valids", 64'({o_arvalid, o_awvalid, o_wvalid}), 64'd0);
    check("rst_axi_readys", 64'({o_rready, o_bready}), 64'd0);

    // Aligned word load.
    run_load("ld_word", 32'h8000_0004, 3'b010, 32'hDEAD_BEEF, RESP_OKAY,
             32'hDEAD_BEEF, 1'b0, 3'd2, 0);
    // Signed and unsigned byte from the top lane.
    run_load("ld_byte_s", 32'h8000_0003, 3'b000, 32'h80FF_FF7F, RESP_OKAY,
             32'hFFFF_FF80, 1'b0, 3'd0, 0);
    run_load("ld_byte_u", 32'h8000_0003, 3'b100, 32'h80FF_FF7F, RESP_OKAY,
             32'h0000_0080, 1'b0, 3'd0, 0);
    // Signed half from the upper lanes.
    run_load("ld_half_s", 32'h8000_0002, 3'b001, 32'h9ABC_1234, RESP_OKAY,
             32'hFFFF_9ABC, 1'b0, 3'd1, 0);
    // Slave error: fault, zero data, held stable under backpressure.
    run_load("ld_slverr", 32'h8000_0010, 3'b010, 32'h5555_AAAA, 2'b10,
             32'h0, 1'b1, 3'd2, 5);

    // Half store, AW accepted three cycles ahead of W.
    issue("st_half", 1'b0, 1'b1, 32'h8000_0002, 32'h0000_1234, 3'b001);
    check("st_awvalid", 64'(o_awvalid), 64'd1);
    check("st_wvalid", 64'(o_wvalid), 64'd1);
    check("st_awaddr", 64'(o_awaddr), 64'h8000_0002);
    check("st_awsize", 64'(o_awsize), 64'd1);
    check("st_wdata_hi", 64'(o_wdata[31:16]), 64'h1234);
    check("st_wstrb", 64'(o_wstrb), 64'b1100);
    check("st_wlast", 64'(o_wlast), 64'd1);
    i_awready = 1'b1;
    step();
    i_awready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("st_aw_dropped", 64'(o_awvalid), 64'd0);
      check("st_w_held", 64'(o_wvalid), 64'd1);
      check("st_wstrb_held", 64'(o_wstrb), 64'b1100);
      check("st_bready_early", 64'(o_bready), 64'd0);
      if (i == 2) i_wready = 1'b1;
      step();
    end
    i_wready = 1'b0;
    check("st_w_dropped", 64'(o_wvalid), 64'd0);
    check("st_bready", 64'(o_bready), 64'd1);
    check("st_valid_in_b", 64'(o_valid), 64'd0);
    i_bvalid = 1'b1; i_bresp = RESP_OKAY;
    step();
    i_bvalid = 1'b0;
    check("st_valid", 64'(o_valid), 64'd1);
    check("st_fault", 64'(o_fault), 64'd0);
    check("st_rdata", 64'(o_rdata), 64'd0);
    check("st_bready_drop", 64'(o_bready), 64'd0);
    retire("st_half");

    // Pass-through: result at cycle 1, no bus activity.
    issue("pass", 1'b0, 1'b0, 32'h8000_0020, 32'hFFFF_FFFF, 3'b010);
    check("pass_valid", 64'(o_valid), 64'd1);
    check("pass_rdata", 64'(o_rdata), 64'd0);
    check("pass_fault", 64'(o_fault), 64'd0);
    check("pass_no_bus", 64'({o_arvalid, o_awvalid, o_wvalid}), 64'd0);
    retire("pass");

    // Dword on a 32-bit bus: immediate fault.
    issue("dword", 1'b1, 1'b0, 32'h8000_0000, 32'h0, 3'b011);
    check("dword_valid", 64'(o_valid), 64'd1);
    check("dword_fault", 64'(o_fault), 64'd1);
    check("dword_rdata", 64'(o_rdata), 64'd0);
    check("dword_no_ar", 64'(o_arvalid), 64'd0);
    retire("dword");

`ifdef LSU_MISALIGN_TRAP_EN
    issue("ld_mis", 1'b1, 1'b0, 32'h8000_0001, 32'h0, 3'b010);
    check("ld_mis_no_ar", 64'(o_arvalid), 64'd0);
    check("ld_mis_valid", 64'(o_valid), 64'd1);
    check("ld_mis_fault", 64'(o_fault), 64'd1);
    retire("ld_mis");
`else
    // Misaligned word: issued as-is, the top lane falls off the result.
    run_load("ld_mis", 32'h8000_0001, 3'b010, 32'hAABB_CCDD, RESP_OKAY,
             32'h00AA_BBCC, 1'b0, 3'd2, 0);
`endif

    // Reset while AW/W are pending.
    issue("st_rst", 1'b0, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 3'b010);
    check("st_rst_awvalid", 64'(o_awvalid), 64'd1);
    check("st_rst_wvalid", 64'(o_wvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_awvalid", 64'(o_awvalid), 64'd0);
    check("rst_async_wvalid", 64'(o_wvalid), 64'd0);
    check("rst_async_ready", 64'(o_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_release_ready", 64'(o_ready), 64'd1);
    check("rst_release_valid", 64'(o_valid), 64'd0);
    run_load("ld_after_rst", 32'h8000_0008, 3'b010, 32'h1234_5678, RESP_OKAY,
             32'h1234_5678, 1'b0, 3'd2, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
